// File: rtl/clock_bank.sv
// clock_bank: multi-channel programmable clock/strobe generator on sysclk.
// Each channel divides sysclk by 2*H into a 50%-duty clock with a one-cycle
// tick on every rising edge. H is reprogrammed through a valid/ready port. A
// new value for a running channel is held pending and applied only at the end
// of a full period, so the output never produces a short phase.
//
// Ports:
//   sysclk     system clock, all logic on the rising edge
//   rst        asynchronous active-low reset
//   cfg_valid  config request
//   cfg_ready  config accept (combinational); transfer on valid && ready
//   cfg_ch     target channel; values >= NUM_CH are accepted and discarded
//   cfg_half   new half-period in sysclk cycles, 0 disables the channel
//   align      synchronous phase-coherent restart of all channels
//   clk_out    divided clocks (registered)
//   tick       one-cycle pulse in the first cycle clk_out[i] is high
//   pending    channel holds an accepted update that is not yet applied
module clock_bank #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SYS_HZ   = 100_000_000,
    parameter int unsigned RST_HALF = SYS_HZ / 2,
    parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              align,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0] busy_vec;
    logic              sel_busy;

    // Selected channel already holds an update; out-of-range selects never busy.
    always_comb begin
        sel_busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i) && busy_vec[i]) begin
                sel_busy = 1'b1;
            end
        end
    end

    assign cfg_ready = ~align & ~sel_busy;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] half_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] pend_val_q;
        logic             q_q;
        logic             tick_q;
        logic             pend_q;
        logic             xfer;
        logic             term;

        assign xfer = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));
        assign term = (cnt_q == half_q - CNT_W'(1));

        // Per-channel divider; pending update lands only at end of high phase.
        always_ff @(posedge sysclk or negedge rst) begin
            if (!rst) begin
                half_q     <= CNT_W'(RST_HALF);
                cnt_q      <= '0;
                pend_val_q <= '0;
                q_q        <= 1'b0;
                tick_q     <= 1'b0;
                pend_q     <= 1'b0;
            end else if (align) begin
                cnt_q  <= '0;
                q_q    <= 1'b0;
                tick_q <= 1'b0;
                if (pend_q) begin
                    half_q <= pend_val_q;
                    pend_q <= 1'b0;
                end
            end else if (half_q == '0) begin
                // Disabled: held low, a new value takes effect next cycle.
                cnt_q  <= '0;
                q_q    <= 1'b0;
                tick_q <= 1'b0;
                if (xfer) begin
                    half_q <= cfg_half;
                end
            end else begin
                if (term) begin
                    cnt_q  <= '0;
                    q_q    <= ~q_q;
                    tick_q <= ~q_q;
                    // Falling edge: restart low with the new half-period.
                    if (q_q && pend_q) begin
                        half_q <= pend_val_q;
                        pend_q <= 1'b0;
                    end
                end else begin
                    cnt_q  <= cnt_q + CNT_W'(1);
                    tick_q <= 1'b0;
                end
                if (xfer) begin
                    pend_val_q <= cfg_half;
                    pend_q     <= 1'b1;
                end
            end
        end

        assign clk_out[g]  = q_q;
        assign tick[g]     = tick_q;
        assign pending[g]  = pend_q;
        assign busy_vec[g] = pend_q;
    end

endmodule

// File: tb/tb_clock_bank.sv
// Bench for clock_bank. The reference model tracks each channel as a
// half-period plus the cycle at which its current run started; output level
// and tick follow from the elapsed count by division, and pending updates
// land where the elapsed count completes a full period.
module tb_clock_bank;

    localparam int unsigned NUM_CH   = 3;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned RST_HALF = 5;
    localparam int unsigned CH_W     = 2;

    logic              sysclk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_half = '0;
    logic              align = 1'b0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    clock_bank #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .SYS_HZ  (10),
        .RST_HALF(RST_HALF)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .align    (align),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    always #5 sysclk = ~sysclk;

    int errors = 0;
    int checks = 0;

    // Model state: cycle index n, per channel half-period, run start, pending.
    longint n = 0;
    longint mh [NUM_CH];
    longint t0 [NUM_CH];
    longint mpv[NUM_CH];
    bit     mp [NUM_CH];

    function automatic logic [NUM_CH-1:0] exp_clk();
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mh[i] != 0) r[i] = (((n - t0[i]) / mh[i]) % 2) == 1;
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_tick();
        logic [NUM_CH-1:0] r;
        longint e;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            e = n - t0[i];
            if (mh[i] != 0) r[i] = (e % mh[i] == 0) && ((e / mh[i]) % 2 == 1);
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_pend();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = mp[i];
        return r;
    endfunction

    function automatic logic exp_ready();
        logic busy;
        busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cfg_ch) == i && mp[i]) busy = 1'b1;
        end
        return !align && !busy;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic check_outputs();
        check("clk_out", 32'(clk_out), 32'(exp_clk()));
        check("tick", 32'(tick), 32'(exp_tick()));
        check("pending", 32'(pending), 32'(exp_pend()));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            mh[i]  = RST_HALF;
            t0[i]  = n;
            mp[i]  = 1'b0;
            mpv[i] = 0;
        end
    endtask

    // Advance the model across one rising edge given this cycle's inputs.
    task automatic model_advance(input bit acc, input bit al);
        longint nn;
        longint e;
        bit     xf;
        nn = n + 1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (al) begin
                if (mp[i]) begin
                    mh[i] = mpv[i];
                    mp[i] = 1'b0;
                end
                t0[i] = nn;
            end else begin
                xf = acc && (int'(cfg_ch) == i);
                if (mh[i] == 0) begin
                    if (xf) begin
                        mh[i] = cfg_half;
                        t0[i] = nn;
                    end
                end else begin
                    e = n - t0[i];
                    if (mp[i] && (e % (2 * mh[i]) == 2 * mh[i] - 1)) begin
                        mh[i] = mpv[i];
                        mp[i] = 1'b0;
                        t0[i] = nn;
                    end
                    if (xf) begin
                        mp[i]  = 1'b1;
                        mpv[i] = cfg_half;
                    end
                end
            end
        end
        n = nn;
    endtask

    // One sysclk cycle: drive inputs, check ready, clock, check outputs.
    task automatic step(input bit v, input int ch, input int half, input bit al);
        bit acc;
        cfg_valid = v;
        cfg_ch    = CH_W'(ch);
        cfg_half  = CNT_W'(half);
        align     = al;
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
        acc = v && exp_ready();
        @(posedge sysclk);
        model_advance(acc, al);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 0, 0, 1'b0);
    endtask

    // Assert reset between edges, hold it across an edge, release mid-cycle.
    task automatic mid_reset();
        cfg_valid = 1'b0;
        align     = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        @(posedge sysclk);
        #1;
        check("rst_hold_clk_out", 32'(clk_out), 32'd0);
        #2 rst = 1'b1;
        model_reset();
        check_outputs();
    endtask

    initial begin
        rst = 1'b0;
        #1;
        check("por_clk_out", 32'(clk_out), 32'd0);
        check("por_tick", 32'(tick), 32'd0);
        check("por_pending", 32'(pending), 32'd0);
        repeat (2) @(posedge sysclk);
        #3 rst = 1'b1;
        n = 0;
        model_reset();
        check_outputs();

        // Default divide, then reprogram ch1 mid-period.
        idle(7);
        step(1'b1, 1, 3, 1'b0);
        idle(25);

        // Stop ch2, then restart it from disabled.
        step(1'b1, 2, 0, 1'b0);
        idle(12);
        step(1'b1, 2, 2, 1'b0);
        idle(10);

        // Mixed half-periods, pending update, then align.
        step(1'b1, 0, 2, 1'b0);
        step(1'b1, 2, 4, 1'b0);
        idle(15);
        step(1'b1, 2, 6, 1'b0);
        idle(3);
        step(1'b0, 0, 0, 1'b1);
        idle(30);

        // Asynchronous reset with an update outstanding.
        step(1'b1, 1, 7, 1'b0);
        mid_reset();
        idle(20);

        // Fastest divide and out-of-range channel select.
        step(1'b1, 0, 1, 1'b0);
        idle(8);
        step(1'b1, 3, 9, 1'b0);
        idle(10);

        // Random traffic including writes to busy channels and aligns.
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 6)), $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
